// File: rtl/add_mul_pkg.sv
// Shared definitions for the add/multiply sequencer: FSM states and operation codes.
package add_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/add_mul_seq.sv
// Sequential unsigned adder / radix-2 shift-add multiplier with a valid/ready
// request port and a valid/ready result port.
module add_mul_seq
  import add_mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               operation,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int RES_W = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [RES_W-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             accept;

  function automatic logic [RES_W-1:0] add_ext(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    return RES_W'(s);
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (operation == OP_MUL) ? MUL : ADD;
      ADD:  state_nxt = DONE;
      MUL:  if (cnt == CNT_LAST) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers: the multiplicand shifts left and the multiplier right,
  // so each MUL cycle only ever inspects mplier[0].
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand  <= RES_W'(a);
      mplier <= b;
    end else if (state == MUL) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // result doubles as the multiply accumulator; it is left alone in DONE so it
  // holds steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (operation == OP_MUL) result <= '0;
          end
        end
        ADD: result <= add_ext(mcand[WIDTH-1:0], mplier);
        MUL: begin
          if (mplier[0]) result <= result + mcand;
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_mul_seq.sv
// Bench for add_mul_seq: directed corner cases on WIDTH=4 and WIDTH=8 instances,
// then a long randomized run against a queue-based reference model.
module tb_add_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 1'b0;
  logic        op = 1'b0;
  logic        ordy = 1'b0;
  logic        use8 = 1'b0;
  logic [7:0]  a_drv = '0;
  logic [7:0]  b_drv = '0;

  logic        iv4, iv8;
  logic        in_ready4, out_valid4, in_ready8, out_valid8;
  logic [7:0]  result4;
  logic [15:0] result8;
  logic        ov, ir;
  logic [15:0] res;

  int nchecks = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign iv4 = iv && !use8;
  assign iv8 = iv && use8;
  assign ov  = use8 ? out_valid8 : out_valid4;
  assign ir  = use8 ? in_ready8 : in_ready4;
  assign res = use8 ? result8 : {8'h00, result4};

  add_mul_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(in_ready4),
    .a(a_drv[3:0]), .b(b_drv[3:0]), .operation(op),
    .out_valid(out_valid4), .out_ready(ordy), .result(result4)
  );

  add_mul_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(in_ready8),
    .a(a_drv), .b(b_drv), .operation(op),
    .out_valid(out_valid8), .out_ready(ordy), .result(result8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request on the selected instance. The consumer can first take the result
  // on edge accept+lat (lat = 2 for add, WIDTH+1 for multiply); hold>0 stalls it.
  task automatic do_op(input logic o, input logic [7:0] x, input logic [7:0] y,
                       input int hold, input string tag);
    int w, lat;
    logic [15:0] exp;
    logic early, stable;
    w   = use8 ? 8 : 4;
    lat = o ? w + 1 : 2;
    exp = o ? 16'(x) * 16'(y) : 16'(x) + 16'(y);
    chk({tag, "_in_ready"}, 32'(ir), 32'd1);
    iv = 1'b1; a_drv = x; b_drv = y; op = o; ordy = (hold == 0);
    tick();
    iv = 1'b0; a_drv = 8'($urandom); b_drv = 8'($urandom); op = 1'($urandom);
    early = 1'b0;
    for (int s = 0; s < lat - 1; s++) begin
      if (ov !== 1'b0) early = 1'b1;
      tick();
    end
    chk({tag, "_early_valid"}, 32'(early), 32'd0);
    chk({tag, "_valid"}, 32'(ov), 32'd1);
    chk({tag, "_result"}, 32'(res), 32'(exp));
    if (hold > 0) begin
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        iv = 1'($urandom_range(0, 1));
        a_drv = 8'($urandom); b_drv = 8'($urandom);
        tick();
        if (ov !== 1'b1 || res !== exp || ir !== 1'b0) stable = 1'b0;
      end
      iv = 1'b0;
      chk({tag, "_held_stable"}, 32'(stable), 32'd1);
      ordy = 1'b1;
    end
    tick();
    chk({tag, "_valid_cleared"}, 32'(ov), 32'd0);
    chk({tag, "_ready_again"}, 32'(ir), 32'd1);
    ordy = 1'b0;
  endtask

  initial begin
    int sent, recv, cyc;
    logic [15:0] q[$];
    logic [15:0] exp;
    logic quiet;

    // Reset state while rst is held.
    #2;
    chk("reset_result4", 32'(result4), 32'd0);
    chk("reset_valid4", 32'(out_valid4), 32'd0);
    chk("reset_ready4", 32'(in_ready4), 32'd1);
    chk("reset_result8", 32'(result8), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // WIDTH=4 directed cases.
    use8 = 1'b0;
    do_op(1'b0, 8'd15, 8'd15, 0, "add_15_15");
    do_op(1'b1, 8'd15, 8'd15, 0, "mul_15_15");
    do_op(1'b1, 8'd0, 8'd9, 0, "mul_0_9");
    do_op(1'b0, 8'd0, 8'd0, 0, "add_0_0");
    do_op(1'b1, 8'd6, 8'd7, 3, "mul_6_7_stall");

    // Reset in the middle of a multiply (5*3: accumulator is already 15).
    iv = 1'b1; a_drv = 8'd5; b_drv = 8'd3; op = 1'b1; ordy = 1'b1;
    tick();
    iv = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid4), 32'd0);
    chk("rst_mid_result", 32'(result4), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_release_ready", 32'(in_ready4), 32'd1);
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid4 !== 1'b0) quiet = 1'b1 & 1'b0;
      tick();
    end
    chk("rst_no_emit", 32'(quiet), 32'd1);
    ordy = 1'b0;
    do_op(1'b0, 8'd3, 8'd4, 0, "rst_then_add");

    // WIDTH=8 boundaries.
    use8 = 1'b1;
    do_op(1'b1, 8'd255, 8'd255, 0, "w8_mul_255");
    do_op(1'b0, 8'd255, 8'd255, 0, "w8_add_255");
    do_op(1'b1, 8'd0, 8'd0, 0, "w8_mul_0");
    do_op(1'b1, 8'd200, 8'd131, 2, "w8_mul_stall");

    // Randomized back-to-back traffic on WIDTH=4 with a random consumer.
    use8 = 1'b0;
    sent = 0; recv = 0; cyc = 0;
    while ((sent < 1000 || q.size() > 0) && cyc < 50000) begin
      iv    = (sent < 1000) && ($urandom_range(0, 3) != 0);
      a_drv = 8'($urandom_range(0, 15));
      b_drv = 8'($urandom_range(0, 15));
      op    = 1'($urandom_range(0, 1));
      ordy  = 1'($urandom_range(0, 1));
      if (iv && ir) begin
        q.push_back(op ? 16'(a_drv) * 16'(b_drv) : 16'(a_drv) + 16'(b_drv));
        sent++;
      end
      if (ov && ordy) begin
        if (q.size() == 0) begin
          nchecks++;
          nerr++;
          $error("FAIL rand_extra_result observed=%0h expected=none", res);
        end else begin
          exp = q.pop_front();
          chk("rand_result", 32'(res), 32'(exp));
        end
        recv++;
      end
      tick();
      cyc++;
    end
    iv = 1'b0;
    ordy = 1'b0;
    chk("rand_sent", 32'(sent), 32'd1000);
    chk("rand_received", 32'(recv), 32'd1000);
    chk("rand_queue_empty", 32'(q.size()), 32'd0);
    for (int i = 0; i < 12; i++) begin
      if (out_valid4 !== 1'b0) recv++;
      tick();
    end
    chk("rand_no_duplicate", 32'(recv), 32'd1000);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/add_mul_seq.md
ADD_MUL_SEQ -- requirements
Module: add_mul_seq

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 operation  input  1  0 = add, 1 = multiply.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  2*WIDTH  sum, zero-extended, or product.

Function
REQ-012 The request handshake SHALL complete on a rising edge where in_valid and in_ready are both 1; a, b and operation SHALL be captured on that edge.
REQ-013 The FSM SHALL have exactly four states: IDLE, ADD, MUL, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE, decoded from registered state; in_valid in other states SHALL be ignored.
REQ-015 IDLE: on handshake go to ADD if operation=0, else to MUL with iteration counter cleared.
REQ-016 ADD: compute a+b as WIDTH+1 bits, zero-extend into result, go to DONE; out_valid SHALL rise 2 cycles after the accept edge.
REQ-017 MUL: radix-2 shift-add, one multiplier bit per cycle, LSB first; run exactly WIDTH iterations with a counter of clog2(WIDTH+1) bits, then go to DONE; out_valid SHALL rise WIDTH+1 cycles after the accept edge.
REQ-018 The product SHALL be exact unsigned a*b in 2*WIDTH bits with no truncation; the accumulator SHALL be 2*WIDTH bits wide.
REQ-019 DONE: out_valid=1; result SHALL hold stable until out_ready=1; on that edge go to IDLE with out_valid=0.
REQ-020 result SHALL be registered; outside DONE its value is don't-care for consumers but SHALL be 0 after reset.
REQ-021 Boundary: operands 0 SHALL give result 0 after full latency (no early exit); all-ones operands SHALL give (2^WIDTH-1)^2 for multiply and 2^(WIDTH+1)-2 for add.
REQ-022 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, counter 0, result 0, out_valid 0, in_ready 1 on release.
REQ-024 Reset during ADD, MUL or DONE SHALL discard the operation; no result SHALL be emitted.

Structure
REQ-025 Shared package add_mul_pkg SHALL hold the FSM state enum and the operation encodings OP_ADD=0 and OP_MUL=1.
REQ-026 No sub-module; FSM, counter and shift-add datapath SHALL reside in add_mul_seq.

Verification (WIDTH=4 unless stated)
REQ-027 Add a=15, b=15, out_ready=1 -> result=0x001E, out_valid high exactly 2 cycles after accept, for one cycle.
REQ-028 Multiply a=15, b=15 -> result=0x00E1 after 5 cycles; a=0, b=9 -> 0x0000 after 5 cycles.
REQ-029 Multiply 6*7 with out_ready held 0 for 3 cycles -> result=0x002A stable and out_valid=1 throughout; in_valid pulses meanwhile ignored.
REQ-030 rst pulsed during MUL iteration 2 -> out_valid=0 and result=0 immediately; in_ready=1 after release; next add 3+4 -> 0x0007.
REQ-031 WIDTH=8, multiply 255*255 -> result=0xFE01 after 9 cycles; add 255+255 -> 0x01FE.
REQ-032 Back-to-back random add/mul over 1000 requests with random out_ready -> every result matches a reference model, none dropped or duplicated.
